pattern_tx: RTL and testbench

- Serial pattern transmitter. Loads a PAT_W-bit pattern and shifts it out MSB-first, one bit per CLK, for a programmable number of repetitions.
- Optional idle gap between repetitions.
- Serves as the stimulus source and transmit end for the serial sequence-detector FSMs; back-to-back mode (GAP=0) exercises overlapping detection.
- Start/busy/done handshake toward a controller; registered serial output toward the detector.

---
 rtl/pattern_tx_pkg.sv | 14 +
 rtl/tx_piso.sv | 36 +++
 rtl/pattern_tx.sv | 200 ++++++++++++++++++++
 tb/tb_pattern_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_tx_pkg.sv
// pattern_tx shared definitions
// FSM state encoding and default parameter values
package pattern_tx_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 4;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SEND = 2'b01;
  localparam logic [1:0] GAPW = 2'b10;
  localparam logic [1:0] FIN  = 2'b11;

endpackage

// File: rtl/tx_piso.sv
// tx_piso: MSB-first parallel-in serial-out shifter
// The MSB leaves on load, so only the lower W-1 bits are stored
module tx_piso #(
  parameter int W  = 4,
  parameter int IW = $clog2(W)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          shift_i,
  input  logic [W-2:0]  din_i,
  output logic          nxt_o,
  output logic [IW-1:0] idx_o
);

  logic [W-2:0]  sh_q;
  logic [IW-1:0] idx_q;

  // load remaining bits and index, or advance one bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      sh_q  <= din_i;
      idx_q <= IW'(W - 1);
    end else if (shift_i) begin
      sh_q  <= sh_q << 1;
      idx_q <= idx_q - IW'(1);
    end
  end

  assign nxt_o = sh_q[W-2];
  assign idx_o = idx_q;

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: repeating serial pattern transmitter
// Optional parity bit per repetition: PATTERN_TX_PARITY_BIT_EN
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic [PAT_W-1:0] PAT,
  input  logic [CNT_W-1:0] REPS,
  input  logic [GAP_W-1:0] GAP,
  output logic             OUT,
  output logic             VALID,
  output logic             LAST,
  output logic             BUSY,
  output logic             DONE
);

  localparam int IW = $clog2(PAT_W);

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [GAP_W-1:0] gap_q;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept, load, shift;
  logic [PAT_W-1:0] ld_pat;
  logic             nxt;
  logic [IW-1:0]    idx;
  logic             bit_end, rep_end;

  assign bit_end = (idx == '0);

`ifdef PATTERN_TX_PARITY_BIT_EN
  logic par_q, par_d;
  assign rep_end = par_q;
`else
  assign rep_end = bit_end;
`endif

  assign ld_pat = accept ? PAT : pat_q;

  tx_piso #(
    .W (PAT_W),
    .IW(IW)
  ) u_piso (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (load),
    .shift_i(shift),
    .din_i  (ld_pat[PAT_W-2:0]),
    .nxt_o  (nxt),
    .idx_o  (idx)
  );

  // next state and next registered outputs
  always_comb begin
    state_d = state_q;
    reps_d  = reps_q;
    gcnt_d  = gcnt_q;
    out_d   = 1'b0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    accept  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
`ifdef PATTERN_TX_PARITY_BIT_EN
    par_d   = 1'b0;
`endif
    if (STOP) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (START) begin
            accept = 1'b1;
            busy_d = 1'b1;
            if (REPS != '0) begin
              state_d = SEND;
              reps_d  = REPS;
              load    = 1'b1;
              out_d   = PAT[PAT_W-1];
              valid_d = 1'b1;
            end else begin
              state_d = FIN;
              done_d  = 1'b1;
            end
          end
        end
        SEND: begin
          busy_d = 1'b1;
          if (rep_end) begin
            reps_d = reps_q - CNT_W'(1);
            if (reps_q == CNT_W'(1)) begin
              state_d = FIN;
              done_d  = 1'b1;
            end else if (gap_q != '0) begin
              state_d = GAPW;
              gcnt_d  = gap_q;
            end else begin
              load    = 1'b1;
              out_d   = pat_q[PAT_W-1];
              valid_d = 1'b1;
            end
`ifdef PATTERN_TX_PARITY_BIT_EN
          end else if (bit_end) begin
            par_d   = 1'b1;
            out_d   = ^pat_q;
            valid_d = 1'b1;
            last_d  = 1'b1;
`endif
          end else begin
            shift   = 1'b1;
            out_d   = nxt;
            valid_d = 1'b1;
`ifndef PATTERN_TX_PARITY_BIT_EN
            last_d  = (idx == IW'(1));
`endif
          end
        end
        GAPW: begin
          busy_d = 1'b1;
          if (gcnt_q == GAP_W'(1)) begin
            state_d = SEND;
            gcnt_d  = '0;
            load    = 1'b1;
            out_d   = pat_q[PAT_W-1];
            valid_d = 1'b1;
          end else begin
            gcnt_d = gcnt_q - GAP_W'(1);
          end
        end
        FIN: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // state, counters and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      reps_q  <= '0;
      gcnt_q  <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reps_q  <= reps_d;
      gcnt_q  <= gcnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // transfer parameters captured on an accepted start
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pat_q <= '0;
      gap_q <= '0;
    end else if (accept) begin
      pat_q <= PAT;
      gap_q <= GAP;
    end
  end

`ifdef PATTERN_TX_PARITY_BIT_EN
  // marks the parity-bit cycle of a repetition
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  assign OUT   = out_q;
  assign VALID = valid_q;
  assign LAST  = last_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed bench with a per-cycle output model
// Model builds the expected cycle stream of each transfer
module tb_pattern_tx;

`ifdef PATTERN_TX_PARITY_BIT_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic o;
    logic v;
    logic l;
    logic b;
    logic d;
  } ov_t;

  logic       CLK, RST, START, STOP;
  logic [3:0] PAT;
  logic [7:0] REPS;
  logic [3:0] GAP;
  logic       OUT, VALID, LAST, BUSY, DONE;

  ov_t q[$];
  ov_t e_v, a_v;
  int  n_vec, n_err;
  int  rel, busy_cnt, done_cnt, valid_cnt, hits, done_at;
  logic [3:0] hist;

  pattern_tx #(
    .PAT_W(4),
    .CNT_W(8),
    .GAP_W(4)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .START(START),
    .STOP (STOP),
    .PAT  (PAT),
    .REPS (REPS),
    .GAP  (GAP),
    .OUT  (OUT),
    .VALID(VALID),
    .LAST (LAST),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // per-cycle compare against the model stream
  always begin
    @(posedge CLK);
    #1;
    e_v = (q.size() != 0) ? q.pop_front() : ov_t'(5'b0);
    a_v = {OUT, VALID, LAST, BUSY, DONE};
    n_vec++;
    if (a_v !== e_v) begin
      n_err++;
      $display("FAIL cycle t=%0t o/v/l/b/d got %b want %b",
               $time, a_v, e_v);
    end
    rel++;
    if (BUSY) busy_cnt++;
    if (DONE) begin
      done_cnt++;
      done_at = rel;
    end
    if (VALID) begin
      valid_cnt++;
      hist = {hist[2:0], OUT};
      if (hist == 4'b1011) hits++;
    end
  end

  task automatic push_model(input logic [3:0] p,
                            input int r, input int g);
    for (int k = 0; k < r; k++) begin
      for (int b = 3; b >= 0; b--)
        q.push_back(ov_t'{p[b], 1'b1, (b == 0) && !PAR,
                          1'b1, 1'b0});
      if (PAR) q.push_back(ov_t'{^p, 1'b1, 1'b1, 1'b1, 1'b0});
      if (k < r - 1)
        for (int j = 0; j < g; j++)
          q.push_back(ov_t'(5'b00010));
    end
    q.push_back(ov_t'(5'b00011));
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic clr();
    rel = 0; busy_cnt = 0; done_cnt = 0;
    valid_cnt = 0; hits = 0; done_at = 0; hist = 4'b0;
  endtask

  task automatic start_tx(input logic [3:0] p,
                          input logic [7:0] r, input logic [3:0] g);
    @(negedge CLK);
    clr();
    PAT = p; REPS = r; GAP = g; START = 1'b1;
    push_model(p, int'(r), int'(g));
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (q.size() == 0) break;
      @(negedge CLK);
    end
    if (i == 3000) begin
      n_err++;
      $display("FAIL timeout queue=%0d", q.size());
      q.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    clr();
    RST = 1'b1; START = 1'b0; STOP = 1'b0;
    PAT = '0; REPS = '0; GAP = '0;
    repeat (3) @(negedge CLK);
    chk("reset_outs", int'({OUT, VALID, LAST, BUSY, DONE}), 0);
    RST = 1'b0;
    @(negedge CLK);

    // async reset during bit 2 of 1011
    start_tx(4'b1011, 8'd3, 4'd0);
    @(negedge CLK);
    chk("bit2_valid", int'(VALID), 1);
    chk("bit2_out", int'(OUT), 0);
    RST = 1'b1;
    q.delete();
    #1;
    chk("async_rst", int'({OUT, VALID, LAST, BUSY, DONE}), 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

`ifndef PATTERN_TX_PARITY_BIT_EN
    // back-to-back, overlapping detection
    start_tx(4'b1011, 8'd3, 4'd0);
    wait_idle();
    chk("b2b_hits", hits, 3);
    chk("b2b_busy", busy_cnt, 13);
    chk("b2b_done_at", done_at, 13);
    chk("b2b_valid", valid_cnt, 12);

    // idle gap between repetitions
    start_tx(4'b1011, 8'd2, 4'd3);
    wait_idle();
    chk("gap_busy", busy_cnt, 12);
    chk("gap_done_at", done_at, 12);
    chk("gap_valid", valid_cnt, 8);
`else
    start_tx(4'b1011, 8'd1, 4'd0);
    wait_idle();
    chk("par_busy", busy_cnt, 6);
    chk("par_done_at", done_at, 6);
    chk("par_valid", valid_cnt, 5);
`endif

    // zero repetitions
    start_tx(4'b1111, 8'd0, 4'd2);
    wait_idle();
    chk("r0_busy", busy_cnt, 1);
    chk("r0_done_at", done_at, 1);
    chk("r0_valid", valid_cnt, 0);

    // start held and inputs changed while busy
    @(negedge CLK);
    clr();
    PAT = 4'b0110; REPS = 8'd2; GAP = 4'd1; START = 1'b1;
    push_model(4'b0110, 2, 1);
    @(negedge CLK);
    PAT = 4'b1111; REPS = 8'd7; GAP = 4'd0;
    repeat (4) @(negedge CLK);
    START = 1'b0;
    wait_idle();
    chk("hold_done", done_cnt, 1);
    chk("hold_valid", valid_cnt, PAR ? 10 : 8);

    // stop wins over start in idle
    @(negedge CLK);
    clr();
    START = 1'b1; STOP = 1'b1; REPS = 8'd1;
    @(negedge CLK);
    START = 1'b0; STOP = 1'b0;
    repeat (3) @(negedge CLK);
    chk("stop_idle_busy", busy_cnt, 0);

    // stop during gap of a 4-rep run
    start_tx(4'b1001, 8'd4, 4'd2);
    repeat (PAR ? 5 : 4) @(negedge CLK);
    chk("in_gap_busy", int'(BUSY), 1);
    chk("in_gap_valid", int'(VALID), 0);
    STOP = 1'b1;
    q.delete();
    @(negedge CLK);
    STOP = 1'b0;
    repeat (3) @(negedge CLK);
    chk("stop_done", done_cnt, 0);
    start_tx(4'b1011, 8'd1, 4'd0);
    wait_idle();
    chk("after_stop_valid", valid_cnt, PAR ? 5 : 4);
    chk("after_stop_done", done_cnt, 1);

    // maximum repetition count
    start_tx(4'b0101, 8'd255, 4'd0);
    wait_idle();
    chk("max_busy", busy_cnt, PAR ? 1276 : 1021);
    chk("max_done", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
